// File: rtl/boot_loader.sv
// Power-on sequencer: copies the program ROM into the CPU program RAM, reads it
// back against the ROM, and only releases the CPU from reset once every word matches.
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_COUNT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reload,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] error_address
);

  typedef enum logic [2:0] {
    IDLE,
    COPY,
    V_READ,
    V_CHECK,
    DONE,
    ERROR
  } state_t;

  // One extra counter bit so a full 2^ADDR_WIDTH image terminates without wrapping.
  localparam int                  LAST_I = WORD_COUNT - 1;
  localparam logic [ADDR_WIDTH:0] LAST   = LAST_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH:0]     count;
  logic [ADDR_WIDTH:0]     count_next;
  logic [ADDR_WIDTH-1:0]   error_address_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      error_address <= '0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      error_address <= error_address_next;
    end
  end

  always_comb begin
    state_next         = state;
    count_next         = count;
    error_address_next = error_address;
    case (state)
      IDLE: begin
        count_next = '0;
        state_next = COPY;
      end
      COPY: begin
        if (count == LAST) begin
          count_next = '0;
          state_next = V_READ;
        end else begin
          count_next = count + ONE;
        end
      end
      V_READ: state_next = V_CHECK;
      // Address is held here so the synchronous RAM read lines up with the ROM word.
      V_CHECK: begin
        if (ram_data_in != rom_data) begin
          error_address_next = count[ADDR_WIDTH-1:0];
          state_next         = ERROR;
        end else if (count == LAST) begin
          state_next = DONE;
        end else begin
          count_next = count + ONE;
          state_next = V_READ;
        end
      end
      DONE: begin
        if (reload) state_next = IDLE;
      end
      ERROR: begin
        if (reload) begin
          error_address_next = '0;
          state_next         = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rom_address      = count[ADDR_WIDTH-1:0];
  assign ram_address      = count[ADDR_WIDTH-1:0];
  assign ram_data_out     = rom_data;
  assign ram_write_enable = (state == COPY);
  assign cpu_reset        = (state != DONE);
  assign done             = (state == DONE);
  assign error            = (state == ERROR);

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: a 9-word instance and a full-depth 1024-word instance,
// each with its own ROM/RAM model; one monitor checks whichever instance is selected.
module tb_boot_loader;
  localparam int AW = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      10'd0: rom_word = 16'h8000;
      10'd1: rom_word = 16'hfffd;
      10'd2: rom_word = 16'h4005;
      10'd3: rom_word = 16'h8000;
      10'd4: rom_word = 16'h8000;
      10'd5: rom_word = 16'h0072;
      10'd6: rom_word = 16'h7005;
      10'd7: rom_word = 16'h2005;
      10'd8: rom_word = 16'h0400;
      default: rom_word = ({6'b0, a} * 16'h9e37) ^ 16'h5a5a;
    endcase
  endfunction

  // 9-word instance
  logic          rst9 = 1'b1, rld9 = 1'b0, fault = 1'b0;
  logic [AW-1:0] rom_a9, ram_a9, ea9;
  logic [DW-1:0] rom_d9, wd9, rd9;
  logic          we9, cpu9, done9, err9;
  logic [DW-1:0] mem9 [0:1023];

  assign rom_d9 = rom_word(rom_a9);
  always @(posedge clk) begin
    if (we9) mem9[ram_a9] <= wd9;
    rd9 <= (fault && ram_a9 == 10'd6) ? 16'h0000 : mem9[ram_a9];
  end

  boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_COUNT(9)) dut9 (
    .clk(clk), .reset(rst9), .reload(rld9),
    .rom_address(rom_a9), .rom_data(rom_d9),
    .ram_address(ram_a9), .ram_data_out(wd9), .ram_write_enable(we9),
    .ram_data_in(rd9), .cpu_reset(cpu9), .done(done9), .error(err9),
    .error_address(ea9)
  );

  // 1024-word instance
  logic          rstk = 1'b1, rldk = 1'b0;
  logic [AW-1:0] rom_ak, ram_ak, eak;
  logic [DW-1:0] rom_dk, wdk, rdk;
  logic          wek, cpuk, donek, errk;
  logic [DW-1:0] memk [0:1023];

  assign rom_dk = rom_word(rom_ak);
  always @(posedge clk) begin
    if (wek) memk[ram_ak] <= wdk;
    rdk <= memk[ram_ak];
  end

  boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_COUNT(1024)) dutk (
    .clk(clk), .reset(rstk), .reload(rldk),
    .rom_address(rom_ak), .rom_data(rom_dk),
    .ram_address(ram_ak), .ram_data_out(wdk), .ram_write_enable(wek),
    .ram_data_in(rdk), .cpu_reset(cpuk), .done(donek), .error(errk),
    .error_address(eak)
  );

  // Monitored view of the selected instance
  logic          sel = 1'b0;
  logic          m_we, m_cpu, m_done, m_err;
  logic [AW-1:0] m_ra, m_rom, m_ea;
  logic [DW-1:0] m_wd;
  assign m_we   = sel ? wek    : we9;
  assign m_cpu  = sel ? cpuk   : cpu9;
  assign m_done = sel ? donek  : done9;
  assign m_err  = sel ? errk   : err9;
  assign m_ra   = sel ? ram_ak : ram_a9;
  assign m_rom  = sel ? rom_ak : rom_a9;
  assign m_ea   = sel ? eak    : ea9;
  assign m_wd   = sel ? wdk    : wd9;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { bit is_err; int at; logic [AW-1:0] ea; } ev_t;
  wr_t wr_q[$];
  ev_t ev_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected writes and done/error events as the DUT presents them.
  logic pd = 1'b0, pe = 1'b0;
  always @(negedge clk) begin : monitor
    wr_t w;
    ev_t e;
    if (m_we) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", m_ra, m_wd);
      end else begin
        w = wr_q.pop_front();
        chk("write_addr", 32'(m_ra), 32'(w.a));
        chk("write_data", 32'(m_wd), 32'(w.d));
      end
    end
    if ((m_done && !pd) || (m_err && !pe)) begin
      if (ev_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: done=%0b error=%0b, none expected", m_done, m_err);
      end else begin
        e = ev_q.pop_front();
        chk("event_is_error", 32'(m_err), 32'(e.is_err));
        chk("event_cycle", cyc, e.at);
        chk("event_cpu_reset", 32'(m_cpu), 32'(e.is_err));
        chk("event_done", 32'(m_done), 32'(!e.is_err));
        if (e.is_err) chk("event_error_address", 32'(m_ea), 32'(e.ea));
      end
    end
    pd <= m_done;
    pe <= m_err;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_pass(input int nwr, input bit has_ev, input bit is_err,
                           input int at, input logic [AW-1:0] ea);
    for (int i = 0; i < nwr; i++) wr_q.push_back('{a: AW'(i), d: rom_word(AW'(i))});
    if (has_ev) ev_q.push_back('{is_err: is_err, at: at, ea: ea});
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((wr_q.size() != 0 || ev_q.size() != 0) && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (wr_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d writes and %0d events still pending", wr_q.size(), ev_q.size());
      wr_q.delete();
      ev_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, 32'(m_cpu), 1);
    chk({tag, "_done"}, 32'(m_done), 0);
    chk({tag, "_error"}, 32'(m_err), 0);
    chk({tag, "_write_enable"}, 32'(m_we), 0);
    chk({tag, "_ram_address"}, 32'(m_ra), 0);
    chk({tag, "_rom_address"}, 32'(m_rom), 0);
    chk({tag, "_error_address"}, 32'(m_ea), 0);
  endtask

  initial begin
    int c;
    step(3);
    chk_reset_vals("reset9");

    // First pass, with a reload pulse landing in V_READ that must be ignored
    rst9 = 1'b0;
    c = cyc;
    push_pass(9, 1'b1, 1'b0, c + 28, '0);
    while (cyc < c + 10) step();
    rld9 = 1'b1;
    step();
    rld9 = 1'b0;
    wait_drain(60);
    for (int i = 0; i < 9; i++) chk("ram_copy", 32'(mem9[i]), 32'(rom_word(AW'(i))));
    step(2);
    chk("done_holds", 32'(m_done), 1);
    chk("cpu_running", 32'(m_cpu), 0);

    // Reload from DONE: CPU back in reset next cycle, then a second full pass
    c = cyc;
    rld9 = 1'b1;
    push_pass(9, 1'b1, 1'b0, c + 29, '0);
    step();
    rld9 = 1'b0;
    chk("reload_cpu_reset", 32'(m_cpu), 1);
    chk("reload_done_low", 32'(m_done), 0);
    wait_drain(60);

    // Word 6 reads back as zero: error at edge 23 of the pass
    fault = 1'b1;
    c = cyc;
    rld9 = 1'b1;
    push_pass(9, 1'b1, 1'b1, c + 25, 10'd6);
    step();
    rld9 = 1'b0;
    wait_drain(60);
    step(3);
    chk("error_holds", 32'(m_err), 1);
    chk("error_cpu_reset", 32'(m_cpu), 1);
    chk("error_done_low", 32'(m_done), 0);
    chk("error_addr_holds", 32'(m_ea), 6);

    // Recovery from ERROR
    fault = 1'b0;
    c = cyc;
    rld9 = 1'b1;
    push_pass(9, 1'b1, 1'b0, c + 29, '0);
    step();
    rld9 = 1'b0;
    chk("recover_error_low", 32'(m_err), 0);
    chk("recover_error_address", 32'(m_ea), 0);
    chk("recover_cpu_reset", 32'(m_cpu), 1);
    wait_drain(60);

    // Reset sampled at edge 4 of a pass, then a clean restart
    rst9 = 1'b1;
    step(2);
    rst9 = 1'b0;
    c = cyc;
    push_pass(4, 1'b0, 1'b0, 0, '0);
    while (cyc < c + 4) step();
    rst9 = 1'b1;
    step();
    chk_reset_vals("midcopy");
    rst9 = 1'b0;
    c = cyc;
    push_pass(9, 1'b1, 1'b0, c + 28, '0);
    wait_drain(60);

    // Full depth instance
    sel = 1'b1;
    step();
    chk_reset_vals("resetk");
    rstk = 1'b0;
    c = cyc;
    push_pass(1024, 1'b1, 1'b0, c + 3073, '0);
    wait_drain(3300);
    chk("full_last_word", 32'(memk[1023]), 32'(rom_word(10'd1023)));
    chk("full_first_word", 32'(memk[0]), 32'(rom_word(10'd0)));
    chk("full_cpu_running", 32'(m_cpu), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
# boot_loader

Power-on sequencer that copies the F100-L program image from the hardcoded program ROM into the CPU's writable program RAM, then reads every word back and compares it against the ROM. It holds the CPU in reset until the copy verifies, and releases it only then. It sits between the ROM, the RAM write/read port and the CPU reset input. A debug `reload` pulse can re-run the whole sequence.

## Interface

Parameters:
- `ADDR_WIDTH`, 10, ROM/RAM word-address width.
- `DATA_WIDTH`, 16, word width.
- `WORD_COUNT`, 1024, number of words to copy. Range is 1..2^ADDR_WIDTH.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `reload`  in  1  single-cycle request to re-run copy and verify. Honoured only in DONE or ERROR.
- `rom_address`  out  ADDR_WIDTH  address to the ROM. The ROM is combinational: `rom_data` is valid in the same cycle.
- `rom_data`  in  DATA_WIDTH  ROM word.
- `ram_address`  out  ADDR_WIDTH  RAM address.
- `ram_data_out`  out  DATA_WIDTH  RAM write data.
- `ram_write_enable`  out  1  RAM write strobe; the write commits on the rising edge.
- `ram_data_in`  in  DATA_WIDTH  RAM read data. The RAM read is synchronous: data is valid the cycle after the address is presented.
- `cpu_reset`  out  1  holds the CPU in reset while high.
- `done`  out  1  copy verified; the CPU is running.
- `error`  out  1  verify mismatch.
- `error_address`  out  ADDR_WIDTH  first mismatching address.

## Operation

The block is a Moore FSM with states IDLE, COPY, V_READ, V_CHECK, DONE and ERROR.

Word counter `count`:
- Width is ADDR_WIDTH+1, so WORD_COUNT = 2^ADDR_WIDTH terminates without wrap.
- `rom_address` and `ram_address` are both `count[ADDR_WIDTH-1:0]`.

Output decoding:
- `ram_write_enable` = (state == COPY).
- `ram_data_out` = `rom_data`.
- `cpu_reset` = 1 in every state except DONE.
- `done` = 1 only in DONE.
- `error` = 1 only in ERROR.

State transitions:
- IDLE: clear `count` and go to COPY.
- COPY: write RAM[count] = ROM[count] each cycle and increment `count`.
  - When `count` == WORD_COUNT-1, clear `count` and go to V_READ.
- V_READ: present `count` to the RAM and ROM, then go to V_CHECK.
- V_CHECK: hold the addresses and compare `ram_data_in` with `rom_data`.
  - On mismatch: latch `error_address` = `count` and go to ERROR.
  - On match and last word: go to DONE.
  - Otherwise: increment `count` and go to V_READ.
- DONE: hold. `reload` = 1 goes to IDLE; `cpu_reset` reasserts in that next cycle.
- ERROR: hold, with the CPU kept in reset. `reload` = 1 clears `error_address` and goes to IDLE.

Boundary rules:
- `reload` is ignored in IDLE, COPY, V_READ and V_CHECK; the sequence is never restarted mid-operation by `reload`.
- `reset` overrides everything in any state, including mid-COPY. The partial RAM contents are simply overwritten by the next pass.
- Only the first mismatch is reported; verification stops there.
- WORD_COUNT = 1: COPY lasts one cycle, then one V_READ/V_CHECK pair.

## Timing

Reset values, visible while `reset` is high and in the cycle after it:
- state = IDLE, `count` = 0, `error_address` = 0.
- `cpu_reset` = 1, `done` = 0, `error` = 0, `ram_write_enable` = 0, both addresses = 0.

Sequence, with edge 0 the first rising edge sampling `reset` = 0:
- Edge 0: IDLE to COPY.
- Edges 1..N (N = WORD_COUNT): commit writes to addresses 0..N-1. Edge N enters V_READ.
- Each verify word takes 2 cycles. The last compare happens at edge 3N, which enters DONE.
- `done` = 1 and `cpu_reset` = 0 from edge 3N onward, so the CPU's first active edge is 3N+1.
- A mismatch on word k enters ERROR at edge N+2k+2.

`reload` latency:
- `reload` sampled high in DONE or ERROR gives IDLE at the next edge.
- The full sequence is then repeated with identical timing, one cycle later than from reset because IDLE takes an extra edge.

## Test plan

- **Copy, N=9, ROM/RAM models:** release reset. Expect:
  - 9 writes carrying the program image 8000, fffd, 4005, 8000, 8000, 0072, 7005, 2005, 0400.
  - `done` rising at edge 27 and `cpu_reset` falling at the same edge.
  - RAM equal to ROM afterwards.
- **Injected fault, N=9:** force RAM word 6 to read 0000. Expect `error` = 1 at edge 23, `error_address` = 6, `cpu_reset` held at 1, `done` = 0.
- **Reset mid-COPY:** assert `reset` at edge 4. Expect:
  - Outputs at reset values on the next edge, `ram_write_enable` = 0.
  - After release, the full sequence restarts from address 0 and `done` rises at edge 27.
- **`reload` handling:**
  - Pulsed during V_READ: ignored, and `done` timing is unchanged.
  - Pulsed in DONE: `cpu_reset` = 1 on the next cycle, and a second full pass completes with `done` again.
- **Full depth, N=1024:** the counter terminates without wrap. The last write goes to address 1023 and `done` asserts at edge 3072.
- **ERROR recovery:** from ERROR, remove the fault and pulse `reload`. Expect `error` = 0 and `error_address` = 0 one cycle later, then `done` after a clean pass.
